// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column per scan tick, reads the
// synchronised rows and runs a press/release debounce FSM per accepted key.
//
// state    | meaning
// SCAN     | advancing one column per tick, looking for any low row
// DEBOUNCE | column frozen, counting consecutive low samples of the captured row
// HELD     | key accepted, key_held high, waiting for the row to go high
// RELEASE  | counting consecutive high samples; any low sample restarts the count
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   deb_cnt;
  logic [3:0]      rs_meta;
  logic [3:0]      rs;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic            tick;
  logic            any_low;
  logic            key_low;

  function automatic logic [1:0] low_idx(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + 1'b1;
  end

  assign tick    = (timer == TICK_LAST);
  assign any_low = ~&rs;
  assign key_low = ~rs[row_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 4'b1110;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              row_idx <= low_idx(rs);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              col     <= {col[2:0], col[3]};
            end
          end
          DEBOUNCE: begin
            if (key_low) begin
              if (deb_cnt == DEB_LAST) begin
                state     <= HELD;
                key_code  <= {row_idx, col_idx};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              // bounce: give up on this column and keep sweeping
              state   <= SCAN;
              col_idx <= col_idx + 2'd1;
              col     <= {col[2:0], col[3]};
            end
          end
          HELD: begin
            if (!key_low) begin
              state   <= RELEASE;
              deb_cnt <= '0;
            end
          end
          RELEASE: begin
            if (!key_low) begin
              if (deb_cnt == DEB_LAST) begin
                state    <= SCAN;
                key_held <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                col      <= {col[2:0], col[3]};
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              deb_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=3 and a
// behavioural 4x4 key matrix; cyc counts clock edges since reset release.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;   // keys[r*4+c] = key at row r / column c is down
  int          cyc;
  int          errors = 0;
  int          checks = 0;

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    keys = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (col !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: col=%b code=%b valid=%b held=%b, want 1110 0000 0 0",
               col, key_code, key_valid, key_held);
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      e = 4'b1111;
      e[(cyc/4)%4] = 1'b0;
      checks++;
      if (col !== e || key_valid !== 1'b0 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL idle_scan cyc=%0d: col=%b valid=%b held=%b, want col=%b valid=0 held=0",
                 cyc, col, key_valid, key_held, e);
      end
      @(posedge clk); #1;
    end
  endtask

  // row 2 / col 1 pressed from release; accepted at the fifth tick (cyc 20)
  task automatic test_press();
    int nv = 0;
    int vcyc = -1;
    logic [3:0] vcode = 4'hx;
    do_reset();
    keys = '0;
    keys[2*4+1] = 1'b1;
    while (cyc < 40) begin
      @(posedge clk); #1;
      if (key_valid) begin
        nv++;
        if (vcyc < 0) begin vcyc = cyc; vcode = key_code; end
      end
      if (cyc == 19) begin
        checks++;
        if (key_held !== 1'b0 || col !== 4'b1101) begin
          errors++;
          $display("FAIL press_pre_accept: held=%b col=%b, want held=0 col=1101", key_held, col);
        end
      end
    end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL press_pulse_count: got %0d, want 1", nv); end
    checks++;
    if (vcyc !== 20) begin errors++; $display("FAIL press_latency: strobe at cyc %0d, want 20", vcyc); end
    checks++;
    if (vcode !== 4'b1001) begin errors++; $display("FAIL press_code: got %b, want 1001", vcode); end
    checks++;
    if (key_held !== 1'b1 || col !== 4'b1101 || key_code !== 4'b1001) begin
      errors++;
      $display("FAIL press_held: held=%b col=%b code=%b, want 1 1101 1001", key_held, col, key_code);
    end
  endtask

  // continues from test_press at cyc 40: first high sample at tick 44, drop at 56
  task automatic test_release();
    int nv = 0;
    int drop = -1;
    logic [3:0] dcol = 4'hx;
    keys = '0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      if (key_valid) nv++;
      if (!key_held && drop < 0) begin drop = cyc; dcol = col; end
    end
    checks++;
    if (drop !== 56) begin errors++; $display("FAIL release_drop: held fell at cyc %0d, want 56", drop); end
    checks++;
    if (dcol !== 4'b1011) begin errors++; $display("FAIL release_col: col=%b, want 1011", dcol); end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL release_strobe: %0d strobes, want 0", nv); end
    checks++;
    if (key_code !== 4'b1001) begin errors++; $display("FAIL release_code_hold: code=%b, want 1001", key_code); end
  endtask

  // high at tick 44, low at tick 48, then high from tick 52: drop at 60
  task automatic test_release_bounce();
    int nv = 0;
    int drop = -1;
    logic [3:0] dcol = 4'hx;
    do_reset();
    keys = '0;
    keys[2*4+1] = 1'b1;
    while (cyc < 40) begin
      @(posedge clk); #1;
      if (key_valid) nv++;
    end
    checks++;
    if (nv !== 1 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL bounce_setup: strobes=%0d held=%b, want 1 and 1", nv, key_held);
    end
    nv = 0;
    keys[2*4+1] = 1'b0;
    while (cyc < 64) begin
      if (cyc == 44) keys[2*4+1] = 1'b1;
      if (cyc == 48) keys[2*4+1] = 1'b0;
      @(posedge clk); #1;
      if (key_valid) nv++;
      if (!key_held && drop < 0) begin drop = cyc; dcol = col; end
    end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL bounce_restrobe: %0d strobes, want 0", nv); end
    checks++;
    if (drop !== 60) begin errors++; $display("FAIL bounce_drop: held fell at cyc %0d, want 60", drop); end
    checks++;
    if (dcol !== 4'b1011) begin errors++; $display("FAIL bounce_col: col=%b, want 1011", dcol); end
  endtask

  // row 0 / col 3: seen at tick 16, gone at tick 20, stable again -> accepted at 48
  task automatic test_press_bounce();
    int nv = 0;
    int vcyc = -1;
    logic [3:0] vcode = 4'hx;
    do_reset();
    keys = '0;
    keys[0*4+3] = 1'b1;
    while (cyc < 56) begin
      @(posedge clk); #1;
      if (cyc == 16) keys[0*4+3] = 1'b0;
      if (cyc == 20) keys[0*4+3] = 1'b1;
      if (key_valid) begin
        nv++;
        if (vcyc < 0) begin vcyc = cyc; vcode = key_code; end
      end
      if (cyc == 19) begin
        checks++;
        if (col !== 4'b0111) begin errors++; $display("FAIL pbounce_frozen: col=%b, want 0111", col); end
      end
      if (cyc == 20) begin
        checks++;
        if (col !== 4'b1110 || key_valid !== 1'b0) begin
          errors++;
          $display("FAIL pbounce_abort: col=%b valid=%b, want 1110 0", col, key_valid);
        end
      end
    end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL pbounce_count: %0d strobes, want 1", nv); end
    checks++;
    if (vcyc !== 48) begin errors++; $display("FAIL pbounce_latency: strobe at cyc %0d, want 48", vcyc); end
    checks++;
    if (vcode !== 4'b0011) begin errors++; $display("FAIL pbounce_code: got %b, want 0011", vcode); end
  endtask

  // rows 1 and 3 in col 0: row 1 wins, accepted at tick 16; then reset while HELD
  task automatic test_reset_held();
    int nv = 0;
    do_reset();
    keys = '0;
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    while (cyc < 20) begin
      @(posedge clk); #1;
      if (key_valid) nv++;
    end
    checks++;
    if (nv !== 1 || key_code !== 4'b0100 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL multirow_code: strobes=%0d code=%b held=%b, want 1 0100 1", nv, key_code, key_held);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (col !== 4'b1110 || key_held !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values: col=%b held=%b code=%b valid=%b, want 1110 0 0000 0",
               col, key_held, key_code, key_valid);
    end
    keys = '0;
    nv = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (key_valid) nv++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (key_valid) nv++;
    end
    checks++;
    if (nv !== 0 || key_held !== 1'b0 || key_code !== 4'd0) begin
      errors++;
      $display("FAIL midreset_after: strobes=%0d held=%b code=%b, want 0 0 0000", nv, key_held, key_code);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_release_bounce();
    test_press_bounce();
    test_reset_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the display digit multiplexer: scans a 4x4 matrix keypad by driving one column low at a time and reading the rows.
- Applies the same slow-tick timebase style as the display side, plus a press/release debounce FSM.
- Emits a one-cycle key_valid strobe with a 4-bit key code to the calculator input logic.
- key_held is a level output that stays high while the key remains down.

Parameters:
SCAN_TICKS, 100000, clk cycles per scan tick (1 ms at 100 MHz); timer width is $clog2(SCAN_TICKS); legal range 2 and above.
DEBOUNCE_SCANS, 20, consecutive tick samples a level must hold before a press or release is accepted; legal range 1 and above.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
row  input  4  keypad rows, active-low (externally pulled up), asynchronous to clk
col  output  4  keypad column drive, active-low, exactly one bit low at all times
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key; held until the next accepted press
key_valid  output  1  one-cycle strobe on press acceptance
key_held  output  1  high from acceptance until release debounce completes

Behaviour:
- Reset values (asynchronous):
  - state=SCAN, col=4'b1110 (col_idx 0), timer=0, deb_cnt=0.
  - key_code=0, key_valid=0, key_held=0.
  - Row synchroniser flops = 4'b1111.
- Row synchroniser: two flops. Only the synchronised row value (rs) is used. Adds 2 cycles of latency.
- Timer: counts 0..SCAN_TICKS-1 and wraps. "Tick" means the cycle where timer==SCAN_TICKS-1. All FSM decisions occur only on tick cycles; in other cycles, state and col hold.
- SCAN:
  - On tick, if any rs bit is low, capture row_idx = lowest-index low bit and go to DEBOUNCE with deb_cnt=0. col is unchanged.
  - Otherwise advance col_idx (3 wraps to 0).
- DEBOUNCE (col frozen):
  - On tick, if rs[row_idx] is low and deb_cnt==DEBOUNCE_SCANS-1: go to HELD, load key_code, and pulse key_valid for exactly that one cycle.
  - On tick, if rs[row_idx] is low otherwise: deb_cnt++.
  - On tick, if rs[row_idx] is high: return to SCAN, advance col_idx, no strobe.
  - With DEBOUNCE_SCANS=1, acceptance happens on the first DEBOUNCE tick.
- HELD (col frozen, key_held=1):
  - On tick, if rs[row_idx] is high, go to RELEASE with deb_cnt=0.
  - Other rows pressed in this or other columns are ignored (no rollover).
- RELEASE (col frozen, key_held=1):
  - On tick, if rs[row_idx] is high and deb_cnt==DEBOUNCE_SCANS-1: go to SCAN, clear key_held, advance col_idx.
  - On tick, if rs[row_idx] is high otherwise: deb_cnt++.
  - On tick, if rs[row_idx] is low: deb_cnt=0 and stay in RELEASE. A bounce never re-strobes key_valid.
- Multiple simultaneous keys in the scanned column: the lowest row index wins.
- Multiple simultaneous keys in different columns: the first column reached by the scan wins.
- key_valid rules:
  - Never asserted in two consecutive cycles.
  - At most one strobe per press/release cycle.
- key_code changes only in the cycle key_valid is asserted.
- Reset mid-operation (any state) returns immediately to reset values. No strobe is generated by the reset itself.
- Latency from a stable press to key_valid:
  - At most 2 + SCAN_TICKS*(4 + DEBOUNCE_SCANS) cycles.
  - At least 2 + SCAN_TICKS*DEBOUNCE_SCANS cycles.
- The press must be present on rs at the SCAN tick of its column. A press shorter than one scan sweep may be missed.

Test Plan (SCAN_TICKS=4, DEBOUNCE_SCANS=3):
- Reset, no keys -> col sequence 1110,1101,1011,0111,1110; each value lasts 4 cycles; key_valid=0 and key_held=0 throughout.
- Hold a stable press at row 2 / col 1 (row=4'b1011 whenever col=4'b1101) -> exactly one key_valid pulse with key_code=4'b1001; key_held=1; col stays 4'b1101 while held.
- Release the key from the previous scenario and keep it released -> key_held drops exactly 3 ticks after the first high sample; scanning resumes at col 4'b1011.
- Release bouncing (high 1 tick, low 1 tick, then high) during RELEASE -> no second key_valid; key_held stays 1 until 3 consecutive high ticks are seen.
- Press bounce lasting 1 tick in DEBOUNCE (key at row 0 / col 3) -> returns to SCAN with no strobe. The next stable press gives key_code=4'b0011.
- Rows 1 and 3 pressed in col 0, then reset asserted while in HELD -> key_code=4'b0100 before reset. After reset: col=4'b1110, key_held=0, key_code=0, and no spurious key_valid.
